// File: rtl/present_sbox_layer_seq.sv
// Sequential PRESENT substitution layer: applies the forward or inverse 4-bit S-box to every
// nibble of a WIDTH-bit word, LANES nibbles per clock, with valid/ready on both sides.
module present_sbox_layer_seq #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned C   = NIB / LANES;
    localparam int unsigned CW  = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sub_w;
    logic [WIDTH-1:0] rot_w;

    function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction

    // Substitute the low LANES nibbles, then rotate right by LANES nibbles; after C steps
    // every nibble has been substituted once and the original nibble order is back.
    always_comb begin
        sub_w = work_q;
        for (int l = 0; l < int'(LANES); l++) begin
            sub_w[4*l +: 4] = mode_q ? sbox_inv(work_q[4*l +: 4]) : sbox_fwd(work_q[4*l +: 4]);
        end
        rot_w = '0;
        for (int i = 0; i < int'(NIB); i++) begin
            rot_w[4*i +: 4] = sub_w[4*((i + int'(LANES)) % int'(NIB)) +: 4];
        end
    end

    // Next-state logic for the FSM, work register, mode and step counter.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    work_d  = in_data;
                    mode_d  = in_inv;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                work_d = rot_w;
                if (cnt_q == CW'(C - 1)) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; reset also aborts any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            work_q  <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decoded from the current state; out_data is gated so it reads 0 outside DONE.
    always_comb begin
        in_ready  = (state_q == StIdle) && !rst;
        busy      = (state_q == StBusy);
        out_valid = (state_q == StDone);
        out_data  = out_valid ? work_q : '0;
    end

endmodule

// File: tb/tb_present_sbox_layer_seq.sv
// Self-checking bench for present_sbox_layer_seq: directed vectors, backpressure, reset abort,
// and a randomized sweep across several WIDTH/LANES configurations against a nibble-table model.
module tb_present_sbox_layer_seq;

    localparam int N = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst;
    logic [N-1:0] in_valid;
    logic [N-1:0] in_inv;
    logic [N-1:0] out_ready;
    logic [N-1:0] in_ready;
    logic [N-1:0] out_valid;
    logic [N-1:0] busy;
    logic [63:0]  in_data  [N];
    logic [63:0]  out_data [N];
    logic [15:0]  out16;

    int n_checks = 0;
    int n_pass   = 0;

    present_sbox_layer_seq #(.WIDTH(64), .LANES(4)) u_l4 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_inv(in_inv[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
    );
    present_sbox_layer_seq #(.WIDTH(64), .LANES(1)) u_l1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_inv(in_inv[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
    );
    present_sbox_layer_seq #(.WIDTH(64), .LANES(2)) u_l2 (
        .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_inv(in_inv[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2])
    );
    present_sbox_layer_seq #(.WIDTH(64), .LANES(16)) u_l16 (
        .clk(clk), .rst(rst[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_data(in_data[3]), .in_inv(in_inv[3]), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .out_data(out_data[3]), .busy(busy[3])
    );
    present_sbox_layer_seq #(.WIDTH(16), .LANES(1)) u_w16 (
        .clk(clk), .rst(rst[4]), .in_valid(in_valid[4]), .in_ready(in_ready[4]),
        .in_data(in_data[4][15:0]), .in_inv(in_inv[4]), .out_valid(out_valid[4]),
        .out_ready(out_ready[4]), .out_data(out16), .busy(busy[4])
    );
    assign out_data[4] = {48'h0, out16};

    function automatic int c_of(input int k);
        case (k)
            0: return 4;
            1: return 16;
            2: return 8;
            3: return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int w_of(input int k);
        return (k == 4) ? 16 : 64;
    endfunction

    // Reference: table lookup per nibble; tables written MSB-first as the value list for 0..F.
    function automatic logic [63:0] model(input logic [63:0] x, input logic inv, input int w);
        logic [63:0] ft;
        logic [63:0] it;
        logic [63:0] r;
        int          v;
        ft = 64'hC56B90AD3EF84712;
        it = 64'h5EF8C12DB463079A;
        r  = '0;
        for (int i = 0; i < w / 4; i++) begin
            v = int'(x[4*i +: 4]);
            r[4*i +: 4] = inv ? it[60 - 4*v +: 4] : ft[60 - 4*v +: 4];
        end
        return r;
    endfunction

    // One full transaction on instance k; lat = edges from the accept edge to out_valid
    // (100 means out_valid never came).
    task automatic do_xfer(input int k, input logic [63:0] d, input logic inv, input bit pre,
                           output logic [63:0] res, output int lat);
        int t;
        t = 0;
        while (in_ready[k] !== 1'b1 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        in_valid[k]  = 1'b1;
        in_data[k]   = d;
        in_inv[k]    = inv;
        out_ready[k] = pre;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        in_data[k]  = ~d;
        in_inv[k]   = ~inv;
        lat = 0;
        while (out_valid[k] !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        res = out_data[k];
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst = '1; in_valid = '0; in_inv = '0; out_ready = '0;
        for (int k = 0; k < N; k++) in_data[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (in_ready[0] !== 1'b0) $display("FAIL rst_in_ready got=%b want=0", in_ready[0]); else n_pass++;
        n_checks++; if (out_valid[0] !== 1'b0) $display("FAIL rst_out_valid got=%b want=0", out_valid[0]); else n_pass++;
        n_checks++; if (busy[0] !== 1'b0) $display("FAIL rst_busy got=%b want=0", busy[0]); else n_pass++;
        n_checks++; if (out_data[0] !== 64'h0) $display("FAIL rst_out_data got=%h want=0", out_data[0]); else n_pass++;
        rst = '0;
        #1;
        n_checks++; if (in_ready[0] !== 1'b1) $display("FAIL post_rst_in_ready got=%b want=1", in_ready[0]); else n_pass++;
        n_checks++; if (out_valid[0] !== 1'b0) $display("FAIL post_rst_out_valid got=%b want=0", out_valid[0]); else n_pass++;
        n_checks++; if (busy[0] !== 1'b0) $display("FAIL post_rst_busy got=%b want=0", busy[0]); else n_pass++;
        n_checks++; if (out_data[0] !== 64'h0) $display("FAIL post_rst_out_data got=%h want=0", out_data[0]); else n_pass++;
    endtask

    task automatic test_vectors();
        logic [63:0] vd [5];
        logic        vi [5];
        logic [63:0] ve [5];
        logic [63:0] res;
        int          lat;
        vd[0] = 64'h0123456789ABCDEF; vi[0] = 1'b0; ve[0] = 64'hC56B90AD3EF84712;
        vd[1] = 64'hC56B90AD3EF84712; vi[1] = 1'b1; ve[1] = 64'h0123456789ABCDEF;
        vd[2] = 64'h0;                vi[2] = 1'b0; ve[2] = 64'hCCCCCCCCCCCCCCCC;
        vd[3] = 64'h0;                vi[3] = 1'b1; ve[3] = 64'h5555555555555555;
        vd[4] = 64'hFFFFFFFFFFFFFFFF; vi[4] = 1'b0; ve[4] = 64'h2222222222222222;
        for (int i = 0; i < 5; i++) begin
            // Last vector runs with out_ready already high before out_valid rises.
            do_xfer(0, vd[i], vi[i], (i == 4), res, lat);
            n_checks++; if (res !== ve[i]) $display("FAIL vec%0d_data got=%h want=%h", i, res, ve[i]); else n_pass++;
            n_checks++; if (lat !== 4) $display("FAIL vec%0d_latency got=%0d want=4", i, lat); else n_pass++;
            n_checks++; if (in_ready[0] !== 1'b1) $display("FAIL vec%0d_ready_after got=%b want=1", i, in_ready[0]); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [63:0] want;
        want = 64'hC56B90AD3EF84712;
        in_valid[0] = 1'b1; in_data[0] = 64'h0123456789ABCDEF; in_inv[0] = 1'b0;
        @(posedge clk); #1;
        n = 0;
        while (out_valid[0] !== 1'b1 && n < 20) begin
            n_checks++; if (busy[0] !== 1'b1) $display("FAIL bp_busy cyc%0d got=%b want=1", n, busy[0]); else n_pass++;
            in_valid[0] = 1'($urandom); in_inv[0] = 1'($urandom); in_data[0] = {$urandom, $urandom};
            @(posedge clk); #1; n++;
        end
        n_checks++; if (n !== 4) $display("FAIL bp_latency got=%0d want=4", n); else n_pass++;
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (out_valid[0] !== 1'b1 || out_data[0] !== want || in_ready[0] !== 1'b0)
                $display("FAIL bp_hold cyc%0d valid=%b data=%h ready=%b want valid=1 data=%h ready=0",
                         c, out_valid[0], out_data[0], in_ready[0], want);
            else n_pass++;
            in_valid[0] = 1'($urandom); in_inv[0] = 1'($urandom); in_data[0] = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        n_checks++; if (in_ready[0] !== 1'b1) $display("FAIL bp_release_ready got=%b want=1", in_ready[0]); else n_pass++;
        n_checks++; if (out_valid[0] !== 1'b0) $display("FAIL bp_release_valid got=%b want=0", out_valid[0]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        logic [63:0] x, res;
        int lat;
        in_valid[0] = 1'b1; in_data[0] = 64'hDEADBEEFCAFEF00D; in_inv[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0)
            $display("FAIL midrst_abort busy=%b valid=%b ready=%b want 0/0/0", busy[0], out_valid[0], in_ready[0]);
        else n_pass++;
        rst[0] = 1'b0;
        #1;
        n_checks++; if (in_ready[0] !== 1'b1) $display("FAIL midrst_ready got=%b want=1", in_ready[0]); else n_pass++;
        n_checks++; if (out_data[0] !== 64'h0) $display("FAIL midrst_data got=%h want=0", out_data[0]); else n_pass++;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid[0] === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL midrst_no_valid got=%b want=0", seen); else n_pass++;
        x = {$urandom, $urandom};
        do_xfer(0, x, 1'b1, 1'b0, res, lat);
        n_checks++; if (res !== model(x, 1'b1, 64)) $display("FAIL midrst_next got=%h want=%h", res, model(x, 1'b1, 64)); else n_pass++;
        n_checks++; if (lat !== 4) $display("FAIL midrst_next_lat got=%0d want=4", lat); else n_pass++;
    endtask

    task automatic test_sweep(input int k);
        logic [63:0] mask, x, y, z;
        int lat, c, w;
        w = w_of(k);
        c = c_of(k);
        mask = (w == 64) ? 64'hFFFFFFFFFFFFFFFF : 64'h000000000000FFFF;
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom} & mask;
            do_xfer(k, x, 1'b0, 1'($urandom), y, lat);
            n_checks++; if (y !== model(x, 1'b0, w)) $display("FAIL sweep%0d_fwd x=%h got=%h want=%h", k, x, y, model(x, 1'b0, w)); else n_pass++;
            n_checks++; if (lat !== c) $display("FAIL sweep%0d_fwd_lat got=%0d want=%0d", k, lat, c); else n_pass++;
            do_xfer(k, y, 1'b1, 1'($urandom), z, lat);
            n_checks++; if (z !== model(y, 1'b1, w)) $display("FAIL sweep%0d_inv y=%h got=%h want=%h", k, y, z, model(y, 1'b1, w)); else n_pass++;
            n_checks++; if (z !== x) $display("FAIL sweep%0d_roundtrip got=%h want=%h", k, z, x); else n_pass++;
            n_checks++; if (lat !== c) $display("FAIL sweep%0d_inv_lat got=%0d want=%0d", k, lat, c); else n_pass++;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        fork
            test_sweep(0);
            test_sweep(1);
            test_sweep(2);
            test_sweep(3);
            test_sweep(4);
        join
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
